// File: rtl/dot_seq.sv
// Dot-product sequencer: streams 8.8 operand pairs into an external MAC,
// paces accumulate commands with a fixed idle gap and captures the final sum.
`timescale 1ns/1ps
module dot_seq #(
    parameter int unsigned MAC_GAP = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  len,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic [15:0] mac_a,
    output logic [15:0] mac_b,
    output logic [3:0]  mac_wrAddr,
    input  logic [15:0] mac_result,
    output logic        busy,
    output logic        done,
    output logic [15:0] result
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FETCH = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [3:0] GAP_LAST  = 4'(MAC_GAP - 1);
    localparam logic [3:0] CMD_IDLE  = 4'd0;
    localparam logic [3:0] CMD_ACC   = 4'd1;
    localparam logic [3:0] CMD_CLEAR = 4'd2;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_remaining;
    logic [3:0]  r_wait_cnt;
    logic        r_aborting;
    logic [15:0] r_mac_a;
    logic [15:0] r_mac_b;
    logic [15:0] r_result;

    logic w_start;
    logic w_abort;
    logic w_accept;
    logic w_enter_done;

    assign w_start      = start && (r_state == S_IDLE);
    assign w_abort      = abort && (r_state != S_IDLE);
    assign w_accept     = in_valid && (r_state == S_FETCH);
    assign w_enter_done = (w_state_next == S_DONE) && (r_state != S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = S_CLEAR;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) w_state_next = S_CLEAR;
                end
                S_CLEAR: begin
                    // A CLEAR reached through abort retires the job silently
                    if (r_aborting)                w_state_next = S_IDLE;
                    else if (r_remaining == 4'd0)  w_state_next = S_DONE;
                    else                           w_state_next = S_FETCH;
                end
                S_FETCH: begin
                    if (in_valid) w_state_next = S_ISSUE;
                end
                S_ISSUE: begin
                    w_state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        w_state_next = (r_remaining != 4'd0) ? S_FETCH : S_DONE;
                    end
                end
                S_DONE: begin
                    w_state_next = S_IDLE;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy       = (r_state != S_IDLE);
        in_ready   = 1'b0;
        done       = 1'b0;
        mac_wrAddr = CMD_IDLE;
        case (r_state)
            S_CLEAR: mac_wrAddr = CMD_CLEAR;
            S_FETCH: in_ready   = 1'b1;
            S_ISSUE: mac_wrAddr = CMD_ACC;
            S_DONE:  done       = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_remaining <= 4'd0;
            r_wait_cnt  <= 4'd0;
            r_aborting  <= 1'b0;
            r_mac_a     <= 16'd0;
            r_mac_b     <= 16'd0;
            r_result    <= 16'd0;
        end else begin
            if (w_start) begin
                r_remaining <= len;
                r_aborting  <= 1'b0;
            end else if (r_state == S_ISSUE) begin
                r_remaining <= r_remaining - 4'd1;
            end

            if (w_abort) begin
                r_aborting <= 1'b1;
            end

            if (r_state == S_ISSUE) begin
                r_wait_cnt <= GAP_LAST;
            end else if ((r_state == S_WAIT) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end

            if (w_accept) begin
                r_mac_a <= in_a;
                r_mac_b <= in_b;
            end

            // An empty job reports zero rather than whatever the MAC holds
            if (w_enter_done) begin
                r_result <= (r_state == S_CLEAR) ? 16'd0 : mac_result;
            end
        end
    end

    assign mac_a  = r_mac_a;
    assign mac_b  = r_mac_b;
    assign result = r_result;

endmodule

// File: tb/tb_dot_seq.sv
// Randomized scoreboard bench for dot_seq with a behavioural 8.8 MAC attached.
`timescale 1ns/1ps
module tb_dot_seq;

    localparam int G    = 5;
    localparam int ELEM = 2 + G;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  len = 4'd0;
    logic [15:0] in_a = 16'd0;
    logic [15:0] in_b = 16'd0;
    logic        in_ready, busy, done;
    logic [3:0]  mac_wrAddr;
    logic [15:0] mac_a, mac_b, mac_result, result;

    always #5 clk = ~clk;

    dot_seq #(.MAC_GAP(G)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_wrAddr (mac_wrAddr),
        .mac_result (mac_result),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    // External MAC: clear on command 2, accumulate the 8.8 product on command 1
    logic [15:0] mac_acc = 16'd0;
    assign mac_result = mac_acc;
    always @(posedge clk) begin
        if (mac_wrAddr == 4'd2)      mac_acc <= 16'd0;
        else if (mac_wrAddr == 4'd1) mac_acc <= mac_acc + 16'((32'(mac_a) * 32'(mac_b)) >> 8);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          issue_cyc[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          clear_cnt = 0;
    int          issue_cnt = 0;
    int          accept_cnt = 0;
    int          rdy_cnt = 0;
    logic [15:0] last_a = 16'd0;
    logic [15:0] last_b = 16'd0;
    logic [15:0] prev_result = 16'd0;
    logic [15:0] job_a[16];
    logic [15:0] job_b[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic monitor();
        logic [3:0] prev_wr;
        exp_t       e;
        prev_wr = 4'd0;
        forever begin
            @(negedge clk);
            check("wr_legal", 32'(mac_wrAddr <= 4'd2), 32'd1);
            if (prev_wr == 4'd1) check("no_back_to_back_issue", 32'(mac_wrAddr == 4'd1), 32'd0);
            if (!busy) check("idle_outputs", 32'({in_ready, done, mac_wrAddr}), 32'd0);
            if (mac_wrAddr == 4'd2) clear_cnt++;
            if (mac_wrAddr == 4'd1) begin
                issue_cnt++;
                issue_cyc.push_back(cyc);
                check("mac_a_at_issue", 32'(mac_a), 32'(last_a));
                check("mac_b_at_issue", 32'(mac_b), 32'(last_b));
            end
            if (in_ready) rdy_cnt++;
            if (reset && in_valid && in_ready) begin
                accept_cnt++;
                last_a = in_a;
                last_b = in_b;
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", 32'(result), 32'(e.res));
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    $display("job done: result=0x%04h cycle=%0d (model 0x%04h cycle=%0d)",
                             result, cyc, e.res, e.cyc);
                end
            end
            prev_wr = mac_wrAddr;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) begin
            job_a[i] = 16'($urandom);
            job_b[i] = 16'($urandom);
        end
    endtask

    // One job: optional FETCH stall before element stall_idx, optional abort in the
    // WAIT of element abort_idx, optional start spam while busy.
    task automatic run_job(input int n, input int stall_idx, input int stall_len,
                           input int abort_idx, input bit spam);
        logic [15:0] exp_res;
        int e, guard, cnt, stall_total, b_clr, b_iss, b_acc;
        bit aborted;
        exp_res = 16'd0;
        for (int i = 0; i < n; i++) exp_res += 16'((32'(job_a[i]) * 32'(job_b[i])) >> 8);
        stall_total = (stall_idx < n) ? stall_len : 0;
        b_clr = clear_cnt;
        b_iss = issue_cnt;
        b_acc = accept_cnt;
        aborted = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        len   = 4'(n);
        e     = cyc;
        if (abort_idx < 0) sb_q.push_back('{exp_res, e + 2 + n * ELEM + stall_total});
        @(posedge clk); #1;
        start = 1'b0;
        len   = 4'($urandom);
        fork
            begin
                for (int i = 0; i < n && !aborted; i++) begin
                    if (i == stall_idx && stall_len > 0) begin
                        in_valid = 1'b0;
                        in_a = 16'($urandom);
                        in_b = 16'($urandom);
                        cnt = 0;
                        guard = 0;
                        while (cnt < stall_len && guard < 200) begin
                            @(negedge clk);
                            guard++;
                            if (in_ready) cnt++;
                        end
                        @(posedge clk); #1;
                    end
                    in_valid = 1'b1;
                    in_a = job_a[i];
                    in_b = job_b[i];
                    guard = 0;
                    do begin
                        @(negedge clk);
                        guard++;
                    end while (!in_ready && guard < 200);
                    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
                    @(posedge clk); #1;
                    if (i == abort_idx) begin
                        repeat (2) begin @(posedge clk); #1; end
                        abort = 1'b1;
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                        abort = 1'b0;
                        check("abort_clear_cmd", 32'(mac_wrAddr), 32'd2);
                        check("abort_busy", 32'(busy), 32'd1);
                        @(posedge clk); #1;
                        check("abort_idle", 32'(busy), 32'd0);
                        check("abort_result_kept", 32'(result), 32'(prev_result));
                        aborted = 1'b1;
                    end
                end
                // Keep offering pairs past len: none may be taken
                if (!aborted) begin
                    in_valid = 1'b1;
                    in_a = 16'($urandom);
                    in_b = 16'($urandom);
                end
                guard = 0;
                while (busy && guard < 400) begin
                    @(posedge clk); #1;
                    guard++;
                end
                if (busy) check("job_timeout", 32'd1, 32'd0);
                in_valid = 1'b0;
            end
            begin
                if (spam) begin
                    for (int j = 0; j < 5; j++) begin
                        @(posedge clk); #1;
                        start = 1'b1;
                        len = 4'($urandom);
                        @(posedge clk); #1;
                        start = 1'b0;
                    end
                end
            end
        join
        if (aborted) begin
            check("abort_clear_count", 32'(clear_cnt - b_clr), 32'd2);
            check("abort_accept_count", 32'(accept_cnt - b_acc), 32'(abort_idx + 1));
            check("abort_issue_count", 32'(issue_cnt - b_iss), 32'(abort_idx + 1));
        end else begin
            check("clear_count", 32'(clear_cnt - b_clr), 32'd1);
            check("accept_count", 32'(accept_cnt - b_acc), 32'(n));
            check("issue_count", 32'(issue_cnt - b_iss), 32'(n));
            if (n > 0 && issue_cyc.size() > b_iss)
                check("first_issue_cycle", 32'(issue_cyc[b_iss]),
                      32'(e + 3 + ((stall_idx == 0) ? stall_len : 0)));
            if (stall_total == 0) begin
                for (int k = b_iss + 1; k < issue_cyc.size(); k++)
                    check("issue_spacing", 32'(issue_cyc[k] - issue_cyc[k-1]), 32'(ELEM));
            end
            prev_result = exp_res;
        end
    endtask

    task automatic empty_job_with_held_start();
        int e, b_clr, b_iss, b_acc, b_rdy;
        b_clr = clear_cnt;
        b_iss = issue_cnt;
        b_acc = accept_cnt;
        b_rdy = rdy_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        len = 4'd0;
        in_valid = 1'b1;
        e = cyc;
        sb_q.push_back('{16'h0000, e + 2});
        // start stays high through CLEAR and DONE; neither may relaunch
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b0;
        check("start_in_done_ignored", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("still_idle", 32'(busy), 32'd0);
        in_valid = 1'b0;
        check("empty_clear_count", 32'(clear_cnt - b_clr), 32'd1);
        check("empty_issue_count", 32'(issue_cnt - b_iss), 32'd0);
        check("empty_accept_count", 32'(accept_cnt - b_acc), 32'd0);
        check("empty_in_ready_cycles", 32'(rdy_cnt - b_rdy), 32'd0);
        prev_result = 16'h0000;
    endtask

    task automatic reset_mid_issue();
        int guard;
        for (int i = 0; i < 6; i++) begin
            job_a[i] = 16'($urandom) | 16'h0001;
            job_b[i] = 16'($urandom) | 16'h0001;
        end
        @(posedge clk); #1;
        start = 1'b1;
        len = 4'd6;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        in_a = job_a[0];
        in_b = job_b[0];
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!in_ready && guard < 200);
        @(posedge clk); #1;
        check("pre_reset_issue", 32'(mac_wrAddr), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_done", 32'(done), 32'd0);
        check("async_reset_in_ready", 32'(in_ready), 32'd0);
        check("async_reset_wr", 32'(mac_wrAddr), 32'd0);
        check("async_reset_mac_a", 32'(mac_a), 32'd0);
        check("async_reset_mac_b", 32'(mac_b), 32'd0);
        check("async_reset_result", 32'(result), 32'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("post_reset_quiet", 32'({busy, mac_wrAddr}), 32'd0);
        end
        prev_result = 16'h0000;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] da[10];
        logic [15:0] db[10];
        da = '{16'h0140, 16'h0280, 16'h0280, 16'h0200, 16'h0300,
               16'h0200, 16'h0140, 16'h0380, 16'h0480, 16'h0200};
        db = '{16'h0180, 16'h0180, 16'h0500, 16'h0200, 16'h0500,
               16'h0300, 16'h0380, 16'h0500, 16'h0400, 16'h0300};
        fork
            monitor();
            begin
                #1 reset = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check("reset_busy", 32'(busy), 32'd0);
                check("reset_done", 32'(done), 32'd0);
                check("reset_in_ready", 32'(in_ready), 32'd0);
                check("reset_wr", 32'(mac_wrAddr), 32'd0);
                check("reset_mac_ab", 32'({mac_a, mac_b}), 32'd0);
                check("reset_result", 32'(result), 32'd0);
                reset = 1'b1;

                for (int i = 0; i < 10; i++) begin
                    job_a[i] = da[i];
                    job_b[i] = db[i];
                end
                run_job(10, 99, 0, -1, 1'b0);
                check("directed_result", 32'(result), 32'h5900);

                empty_job_with_held_start();

                fill_random();
                run_job(3, 1, 4, -1, 1'b0);

                fill_random();
                run_job(5, 99, 0, 1, 1'b0);

                fill_random();
                run_job(3, 99, 0, -1, 1'b1);

                for (int r = 0; r < 8; r++) begin
                    fill_random();
                    run_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                            int'($urandom_range(0, 4)), -1, 1'b0);
                end

                reset_mid_issue();
                repeat (5) @(posedge clk);
            end
        join_any
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dot_seq.md
DOT_SEQ -- requirements
Module: dot_seq

Interface
REQ-001 The block SHALL have parameter MAC_GAP, default 5: idle cycles (mac_wrAddr=0) held after each accumulate issue, range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: begin a dot-product job; sampled only in IDLE.
REQ-005 The block SHALL have port len, input, 4 bits: element count, sampled with start; 0 means empty job.
REQ-006 The block SHALL have port abort, input, 1 bit: cancel the current job.
REQ-007 The block SHALL have port in_valid, input, 1 bit: an operand pair is present on in_a/in_b.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts the pair this cycle.
REQ-009 The block SHALL have ports in_a and in_b, input, 16 bits each: operands in 8.8 fixed point.
REQ-010 The block SHALL have ports mac_a and mac_b, output, 16 bits each: operands driven to the MAC datapath.
REQ-011 The block SHALL have port mac_wrAddr, output, 4 bits: MAC command; 0 = idle, 1 = accumulate, 2 = clear.
REQ-012 The block SHALL have port mac_result, input, 16 bits: MAC accumulator value.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse when result is valid.
REQ-015 The block SHALL have port result, output, 16 bits: the captured dot product, held until the next done.

Function
REQ-016 The FSM SHALL have the states IDLE, CLEAR, FETCH, ISSUE, WAIT and DONE.
REQ-017 In IDLE, start=1 at edge k SHALL latch len into a remaining counter and enter CLEAR for cycle k+1.
REQ-018 CLEAR SHALL last exactly 1 cycle with mac_wrAddr=2, then go to FETCH, or to DONE if len=0.
REQ-019 FETCH SHALL drive in_ready=1; in_ready SHALL be 0 in all other states.
REQ-020 In FETCH, in_valid & in_ready SHALL register in_a/in_b into mac_a/mac_b and go to ISSUE; with in_valid=0 the block SHALL stay in FETCH indefinitely.
REQ-021 ISSUE SHALL last exactly 1 cycle with mac_wrAddr=1 and stable mac_a/mac_b, and SHALL decrement the remaining counter.
REQ-022 WAIT SHALL last exactly MAC_GAP cycles with mac_wrAddr=0 and mac_a/mac_b held; it then goes to FETCH if remaining>0, else to DONE.
REQ-023 On entry to DONE, result SHALL be loaded from mac_result, or 0 if len=0; done=1 for that single cycle; the next state SHALL be IDLE.
REQ-024 Per-element cost with in_valid held high SHALL be 2+MAC_GAP cycles.
REQ-025 Start-to-done latency SHALL be 2+len*(2+MAC_GAP) cycles, with done asserted in cycle k+that value.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 start asserted in the same cycle done is high SHALL be ignored; a new job needs start in IDLE.
REQ-028 abort=1 in any non-IDLE state SHALL force CLEAR on the next cycle, then IDLE without done; result SHALL be unchanged.
REQ-029 abort SHALL take priority over all other transitions.
REQ-030 mac_wrAddr SHALL never take a value other than 0, 1 or 2.
REQ-031 The block SHALL never drive 1 on mac_wrAddr for two consecutive cycles.
REQ-032 The block SHALL never accept more than len pairs per job; in_valid beyond len SHALL stay unaccepted.

Reset
REQ-033 reset=0 SHALL asynchronously force state IDLE, mac_wrAddr=0, mac_a=0, mac_b=0, result=0, done=0, busy=0, in_ready=0, and remaining=0.
REQ-034 Deasserting reset SHALL produce no MAC command until a start.
REQ-035 reset asserted mid-job SHALL discard the job without a done pulse.

Verification
REQ-036 Reset for 3 cycles, then start with len=10 and MAC_GAP=5, feeding pairs A=0140,0280,0280,0200,0300,0200,0140,0380,0480,0200 and B=0180,0180,0500,0200,0500,0300,0380,0500,0400,0300 with in_valid always high into a behavioural 8.8 MAC model -> exactly one mac_wrAddr=2 pulse, then 10 wrAddr=1 pulses 7 cycles apart, done at start+72, result=16'h5900.
REQ-037 len=0 -> CLEAR for 1 cycle, done at start+2, result=0000, no wrAddr=1 issued, in_ready never high.
REQ-038 len=3 with in_valid low for 4 cycles before the second pair -> FETCH stretches by 4, done at start+2+3*7+4=start+27, and the pair count is exactly 3.
REQ-039 abort during the WAIT of element 2 of 5 -> next cycle mac_wrAddr=2, then IDLE, no done, result keeps its previous value.
REQ-040 start pulses repeatedly while busy, and reset=0 asserted mid-ISSUE -> extra starts have no effect; on reset all outputs are 0 immediately without waiting for a clock edge.
